// File: rtl/id_regfile.sv
// id_regfile: RV32 architectural integer register file.
// Two combinational read ports, one synchronous write-back port, and a
// per-register pending-write scoreboard for ID-stage hazard detection.
// x0 is hardwired to zero and is never marked busy.
// Optional feature: define REGFILE_BYPASS_EN to forward a same-cycle
// write-back onto the read ports and mask their busy flags.
module id_regfile #(
   parameter int unsigned RADDR_WIDTH = 5,
   parameter int unsigned RDATA_WIDTH = 32,
   parameter int unsigned REG_NUM     = 2 ** RADDR_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [RADDR_WIDTH-1:0] reg1_raddr_i,
   input  logic                   reg1_re_i,
   output logic [RDATA_WIDTH-1:0] reg1_rdata_o,
   output logic                   reg1_busy_o,
   input  logic [RADDR_WIDTH-1:0] reg2_raddr_i,
   input  logic                   reg2_re_i,
   output logic [RDATA_WIDTH-1:0] reg2_rdata_o,
   output logic                   reg2_busy_o,
   input  logic                   reg_we_i,
   input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
   input  logic [RDATA_WIDTH-1:0] reg_wdata_i,
   input  logic                   busy_set_i,
   input  logic [RADDR_WIDTH-1:0] busy_addr_i
);

   logic [RDATA_WIDTH-1:0] regs [REG_NUM];
   logic [REG_NUM-1:0]     busy;

   // Write-back into storage; x0 is never written.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < REG_NUM; i++) begin
            regs[i] <= '0;
         end
      end else if (reg_we_i && (reg_waddr_i != '0)) begin
         regs[reg_waddr_i] <= reg_wdata_i;
      end
   end

   // Pending-write scoreboard: write-back clears, issue sets.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         // The set is issued after the clear so that, for the same
         // address, the newer in-flight writer wins.
         if (reg_we_i) begin
            busy[reg_waddr_i] <= 1'b0;
         end
         if (busy_set_i && (busy_addr_i != '0)) begin
            busy[busy_addr_i] <= 1'b1;
         end
      end
   end

   // Read port 1: zero when disabled or addressing x0.
   always_comb begin
      reg1_rdata_o = '0;
      reg1_busy_o  = 1'b0;
      if (reg1_re_i && (reg1_raddr_i != '0)) begin
         reg1_rdata_o = regs[reg1_raddr_i];
         reg1_busy_o  = busy[reg1_raddr_i];
`ifdef REGFILE_BYPASS_EN
         // Forwarding is suppressed during reset so reads stay 0.
         if (rst_n && reg_we_i && (reg_waddr_i == reg1_raddr_i)) begin
            reg1_rdata_o = reg_wdata_i;
            reg1_busy_o  = 1'b0;
         end
`endif
      end
   end

   // Read port 2: identical behaviour to port 1.
   always_comb begin
      reg2_rdata_o = '0;
      reg2_busy_o  = 1'b0;
      if (reg2_re_i && (reg2_raddr_i != '0)) begin
         reg2_rdata_o = regs[reg2_raddr_i];
         reg2_busy_o  = busy[reg2_raddr_i];
`ifdef REGFILE_BYPASS_EN
         if (rst_n && reg_we_i && (reg_waddr_i == reg2_raddr_i)) begin
            reg2_rdata_o = reg_wdata_i;
            reg2_busy_o  = 1'b0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_id_regfile.sv
// tb_id_regfile: directed, table-driven bench for id_regfile.
// Expectations adapt to REGFILE_BYPASS_EN when it is defined.
module tb_id_regfile;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic [4:0]  reg1_raddr_i, reg2_raddr_i, reg_waddr_i, busy_addr_i;
   logic        reg1_re_i, reg2_re_i, reg_we_i, busy_set_i;
   logic [31:0] reg1_rdata_o, reg2_rdata_o, reg_wdata_i;
   logic        reg1_busy_o, reg2_busy_o;

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;

   id_regfile #(.RADDR_WIDTH(5), .RDATA_WIDTH(32), .REG_NUM(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .reg1_raddr_i (reg1_raddr_i),
      .reg1_re_i    (reg1_re_i),
      .reg1_rdata_o (reg1_rdata_o),
      .reg1_busy_o  (reg1_busy_o),
      .reg2_raddr_i (reg2_raddr_i),
      .reg2_re_i    (reg2_re_i),
      .reg2_rdata_o (reg2_rdata_o),
      .reg2_busy_o  (reg2_busy_o),
      .reg_we_i     (reg_we_i),
      .reg_waddr_i  (reg_waddr_i),
      .reg_wdata_i  (reg_wdata_i),
      .busy_set_i   (busy_set_i),
      .busy_addr_i  (busy_addr_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        re1;
      logic [4:0]  a1;
      logic        re2;
      logic [4:0]  a2;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        bs;
      logic [4:0]  ba;
      logic [31:0] d1;
      logic        b1;
      logic [31:0] d2;
      logic        b2;
   } vec_t;

   localparam int NV = 17;
   vec_t tbl [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic drive(input logic re1, input logic [4:0] a1, input logic re2, input logic [4:0] a2,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic bs, input logic [4:0] ba);
      reg1_re_i = re1; reg1_raddr_i = a1;
      reg2_re_i = re2; reg2_raddr_i = a2;
      reg_we_i = we; reg_waddr_i = wa; reg_wdata_i = wd;
      busy_set_i = bs; busy_addr_i = ba;
   endtask

   task automatic check_ports(input string name, input logic [31:0] d1, input logic b1,
                              input logic [31:0] d2, input logic b2);
      check({name, ".d1"}, reg1_rdata_o, d1);
      check({name, ".b1"}, {31'd0, reg1_busy_o}, {31'd0, b1});
      check({name, ".d2"}, reg2_rdata_o, d2);
      check({name, ".b2"}, {31'd0, reg2_busy_o}, {31'd0, b2});
   endtask

   initial begin
      tbl[0]  = '{"wr_x7_same",   1,7, 1,7, 1,7,32'hDEADBEEF, 0,0,
                  BYP ? 32'hDEADBEEF : 32'h0, 0, BYP ? 32'hDEADBEEF : 32'h0, 0};
      tbl[1]  = '{"rd_x7",        1,7, 1,7, 0,0,32'h0, 0,0, 32'hDEADBEEF,0, 32'hDEADBEEF,0};
      tbl[2]  = '{"wr_x0_same",   1,0, 1,0, 1,0,32'hFFFFFFFF, 0,0, 32'h0,0, 32'h0,0};
      tbl[3]  = '{"rd_x0",        1,0, 1,0, 0,0,32'h0, 0,0, 32'h0,0, 32'h0,0};
      tbl[4]  = '{"re1_low",      0,7, 1,7, 0,0,32'h0, 0,0, 32'h0,0, 32'hDEADBEEF,0};
      tbl[5]  = '{"wr_x9_same",   1,9, 1,9, 1,9,32'hA5A5A5A5, 0,0,
                  BYP ? 32'hA5A5A5A5 : 32'h0, 0, BYP ? 32'hA5A5A5A5 : 32'h0, 0};
      tbl[6]  = '{"rd_x9",        1,9, 1,9, 0,0,32'h0, 0,0, 32'hA5A5A5A5,0, 32'hA5A5A5A5,0};
      tbl[7]  = '{"set_x3",       0,0, 1,3, 0,0,32'h0, 1,3, 32'h0,0, 32'h0,0};
      tbl[8]  = '{"busy_x3",      1,3, 1,3, 0,0,32'h0, 0,0, 32'h0,1, 32'h0,1};
      tbl[9]  = '{"wb_x3",        1,3, 1,3, 1,3,32'h33, 0,0,
                  BYP ? 32'h33 : 32'h0, !BYP, BYP ? 32'h33 : 32'h0, !BYP};
      tbl[10] = '{"cleared_x3",   1,3, 1,3, 0,0,32'h0, 0,0, 32'h33,0, 32'h33,0};
      tbl[11] = '{"set_wb_x3",    1,3, 1,3, 1,3,32'h44, 1,3,
                  BYP ? 32'h44 : 32'h33, 0, BYP ? 32'h44 : 32'h33, 0};
      tbl[12] = '{"set_wins_x3",  1,3, 1,3, 0,0,32'h0, 0,0, 32'h44,1, 32'h44,1};
      tbl[13] = '{"set_x0",       1,0, 1,0, 0,0,32'h0, 1,0, 32'h0,0, 32'h0,0};
      tbl[14] = '{"set4_clr3",    1,3, 1,4, 1,3,32'h55, 1,4,
                  BYP ? 32'h55 : 32'h44, !BYP, 32'h0, 0};
      tbl[15] = '{"after_4_3",    1,3, 1,4, 0,0,32'h0, 0,0, 32'h55,0, 32'h0,1};
      tbl[16] = '{"re_low_busy4", 0,4, 0,4, 0,0,32'h0, 0,0, 32'h0,0, 32'h0,0};

      rst_n = 1'b0;
      drive(0,0, 0,0, 0,0,32'h0, 0,0);
      #1;
      check_ports("in_reset", 32'h0, 0, 32'h0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // All registers read zero and idle after reset.
      for (int i = 1; i < 32; i++) begin
         @(negedge clk);
         drive(1, 5'(i), 1, 5'(i), 0,0,32'h0, 0,0);
         #1;
         check_ports($sformatf("reset_x%0d", i), 32'h0, 0, 32'h0, 0);
      end

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(tbl[i].re1, tbl[i].a1, tbl[i].re2, tbl[i].a2, tbl[i].we, tbl[i].wa, tbl[i].wd,
               tbl[i].bs, tbl[i].ba);
         #1;
         check_ports(tbl[i].name, tbl[i].d1, tbl[i].b1, tbl[i].d2, tbl[i].b2);
      end

      // Asynchronous reset mid-run: x5 and busy x4 vanish without a clock edge.
      @(negedge clk);
      drive(0,0, 0,0, 1,5,32'h1234, 0,0);
      @(negedge clk);
      drive(1,5, 1,4, 0,0,32'h0, 0,0);
      #1;
      check_ports("pre_rst", 32'h1234, 0, 32'h0, 1);
      #1 rst_n = 1'b0;
      #1;
      check_ports("async_rst", 32'h0, 0, 32'h0, 0);

      // Write presented while in reset is discarded and not forwarded.
      drive(1,6, 1,6, 1,6,32'h66, 1,6);
      #1;
      check_ports("rst_wr", 32'h0, 0, 32'h0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1,6, 1,6, 0,0,32'h0, 0,0);
      #1;
      check_ports("rst_wr_lost", 32'h0, 0, 32'h0, 0);

      // First edge after release takes the write.
      @(negedge clk);
      drive(0,0, 0,0, 1,6,32'h77, 0,0);
      @(negedge clk);
      drive(1,6, 1,5, 0,0,32'h0, 0,0);
      #1;
      check_ports("post_rst_wr", 32'h77, 0, 32'h0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/id_regfile.md
# id_regfile

Architectural integer register file for the RV32 core: the responder on the ID-stage register read interface and the sink for write-back. Serves two combinational read ports, one synchronous write port, and a per-register pending-write scoreboard so ID can detect operands still in flight. Reads are same-cycle, so decoders can drive operands straight from `reg1_rdata_o`/`reg2_rdata_o`. Sits between the ID decoders and the WB stage.

## Interface
- `REG_NUM`, 32: number of architectural registers, equal to 2^`RADDR_WIDTH`.
- `clk` input 1: core clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `reg1_raddr_i` input `RADDR_WIDTH`: read port 1 address (rs1).
- `reg1_re_i` input 1: read port 1 enable (`READ_ENABLE`).
- `reg1_rdata_o` output `RDATA_WIDTH`: read port 1 data.
- `reg1_busy_o` output 1: rs1 has an outstanding write.
- `reg2_raddr_i`, `reg2_re_i`, `reg2_rdata_o`, `reg2_busy_o`: same as port 1, for rs2.
- `reg_we_i` input 1: write-back enable (`WRITE_ENABLE`).
- `reg_waddr_i` input `RADDR_WIDTH`: write-back address (rd).
- `reg_wdata_i` input `RDATA_WIDTH`: write-back data.
- `busy_set_i` input 1: ID issued an instruction that will write `busy_addr_i`.
- `busy_addr_i` input `RADDR_WIDTH`: register to mark pending.

## Operation
- Storage: `REG_NUM` × `RDATA_WIDTH` registers. x0 (`ZERO_REG`) is never written, always reads 0, and is never busy.
- Write: on the rising edge, if `reg_we_i` and `reg_waddr_i` != 0, store `reg_wdata_i` at `reg_waddr_i`.
- Read, combinational:
  - If `regN_re_i` is low, or the address is 0: `regN_rdata_o` = 0.
  - Otherwise `regN_rdata_o` = the stored value, subject to the bypass rule in Configuration.
- Scoreboard: one `busy` bit per register.
  - Set on the edge when `busy_set_i` is high and `busy_addr_i` != 0.
  - Cleared on the edge when `reg_we_i` is high and the write address matches.
  - Set and clear in the same cycle to the same address: set wins, because a newer writer is in flight.
  - Set and clear to different addresses: both take effect.
- `regN_busy_o` = `regN_re_i` & `busy[regN_raddr_i]` & (`regN_raddr_i` != 0).
  - With bypass compiled in, it is additionally masked low when a same-cycle write to that address is in progress.
- Both read ports addressing the same register return identical data and busy.
- Writing x0 while x0 is busy: not possible, since x0 is never set.

## Timing
- Read latency: 0 cycles, combinational from address and enable.
- Write latency: 1 edge. Data is visible through storage in the cycle after `reg_we_i` is sampled.
- Scoreboard latency: a busy set is visible on `regN_busy_o` in the cycle after `busy_set_i`.
- Reset, asynchronous on `rst_n` low and regardless of `clk`:
  - All registers are cleared to 0 and all busy bits are cleared.
  - All outputs are 0 while reset is asserted and enables are low.
  - Reads during reset return 0.
  - A write presented in the same cycle that reset is asserted is discarded.
  - Reset mid-operation discards all pending busy state; there is no recovery handshake.
- Release of reset is sampled synchronously; the first write takes effect on the first rising edge with `rst_n` high.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - Write-to-read forwarding. If `reg_we_i` is high, `reg_waddr_i` == `regN_raddr_i` != 0 and `regN_re_i` is high, then `regN_rdata_o` = `reg_wdata_i` in the same cycle and `regN_busy_o` = 0.
- `REGFILE_BYPASS_EN` undefined:
  - Reads always return stored contents; a same-cycle write is visible only from the next cycle.
  - `regN_busy_o` stays high during the write cycle and drops the cycle after.

## Test plan
- Reset, then read x1–x31 with both enables high -> all data 0 and all busy 0. Assert `rst_n` low mid-run after writing x5=0x1234 -> x5 reads 0 immediately, without waiting for a clock edge.
- Write x7=0xDEADBEEF, then read x7 on both ports next cycle -> both return 0xDEADBEEF. Write x0=0xFFFFFFFF -> x0 reads 0.
- Read x7 with `reg1_re_i`=0 -> `reg1_rdata_o`=0 and `reg1_busy_o`=0.
- Same-cycle write x9=0xA5A5A5A5 while reading x9 with the old value 0:
  - With `REGFILE_BYPASS_EN` -> returns 0xA5A5A5A5 and busy 0.
  - Without -> returns 0, then 0xA5A5A5A5 the next cycle.
- Scoreboard: `busy_set_i` on x3 -> `reg2_busy_o`=1 next cycle when reading x3. Write-back x3 -> busy 0 the following cycle. Set x3 and write x3 in the same cycle -> busy stays 1. `busy_set_i` on x0 -> busy never asserts.
